// File: rtl/prime_check_scheduler_if.sv
// Request/response bundle between the requesting agents and the shared prime checker.
// The master side is the agents plus response consumer; the slave side is the scheduler.
interface prime_check_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_num;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [W-1:0]         rsp_num;
    logic                 rsp_prime;
    logic                 busy;

    modport master (
        output req_valid, req_num, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_num, rsp_prime, busy
    );

    modport slave (
        input  req_valid, req_num, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_num, rsp_prime, busy
    );
endinterface

// File: rtl/prime_check_scheduler.sv
// Round-robin scheduler sharing one trial-division primality engine among NUM_REQ agents.
// One divisor is tried per cycle; the result is held on the response port until taken.
module prime_check_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int W       = 8,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    prime_check_scheduler_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TEST = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [W-1:0]    num_q, num_d;
    logic [W-1:0]    d_q, d_d;
    logic            prime_q, prime_d;

    logic            lo_found, hi_found, found;
    logic [ID_W-1:0] lo_winner, hi_winner, winner;
    logic [W-1:0]    win_num;
    logic [2*W-1:0]  d_sq;
    logic            divides;

    // Lowest valid lane at or after rr_ptr wins; otherwise wrap to the lowest valid lane.
    always_comb begin
        lo_found  = 1'b0;
        hi_found  = 1'b0;
        lo_winner = '0;
        hi_winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                lo_found  = 1'b1;
                lo_winner = ID_W'(k);
                if (ID_W'(k) >= rr_ptr_q) begin
                    hi_found  = 1'b1;
                    hi_winner = ID_W'(k);
                end
            end
        end
        found  = lo_found;
        winner = hi_found ? hi_winner : lo_winner;
    end

    always_comb begin
        win_num = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == winner) win_num = bus.req_num[k*W +: W];
        end
    end

    always_comb begin
        bus.req_ready = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            bus.req_ready[k] = (state_q == S_IDLE) && found && !reset && (ID_W'(k) == winner);
        end
    end

    // Square at double width so the stop condition never overflows.
    assign d_sq    = {{W{1'b0}}, d_q} * {{W{1'b0}}, d_q};
    assign divides = (d_q != '0) && ((num_q % d_q) == '0);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        num_d    = num_q;
        d_d      = d_q;
        prime_d  = prime_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    num_d    = win_num;
                    id_d     = winner;
                    rr_ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
                    d_d      = W'(2);
                    if (win_num < W'(2)) begin
                        prime_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_TEST;
                    end
                end
            end
            S_TEST: begin
                if (d_sq > {{W{1'b0}}, num_q}) begin
                    prime_d = 1'b1;
                    state_d = S_DONE;
                end else if (divides) begin
                    prime_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    d_d = d_q + W'(1);
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            num_q    <= '0;
            d_q      <= '0;
            prime_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            num_q    <= num_d;
            d_q      <= d_d;
            prime_q  <= prime_d;
        end
    end

    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_num   = num_q;
    assign bus.rsp_prime = prime_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
